// File: rtl/traffic_phase_sequencer.sv
// Intersection phase sequencer: walks N_PHASES phases with per-phase second durations taken
// from run-time tables, with a sensor-chosen table, a skippable pedestrian phase and optional per-phase holds.
module traffic_phase_sequencer #(
  parameter int                  N_PHASES    = 8,
  parameter int                  N_TABLES    = 4,
  parameter int                  TIME_W      = 8,
  parameter int                  CLK_PER_SEC = 10000,
  parameter int                  PED_PHASE   = 0,
  parameter bit                  SKIP_PED    = 1'b1,
  parameter logic [N_PHASES-1:0] HOLD_MASK   = 'h40,
  localparam int                 PW          = (N_PHASES > 1) ? $clog2(N_PHASES) : 1,
  localparam int                 PSW         = $clog2(CLK_PER_SEC)
) (
  input  logic                                 CLK,
  input  logic                                 reset_general,
  input  logic                                 enable_general,
  input  logic                                 SNN,
  input  logic                                 SNS,
  input  logic                                 STH,
  input  logic                                 ped_btn,
  input  logic                                 hold_ok,
  input  logic [N_TABLES*N_PHASES*TIME_W-1:0]  cfg_dur,
  output logic [PW-1:0]                        phase,
  output logic                                 phase_valid,
  output logic                                 phase_start,
  output logic [1:0]                           table_sel,
  output logic [TIME_W-1:0]                    sec_elapsed,
  output logic                                 ped_pending,
  output logic                                 hold_wait
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_phase, w_phase_nxt;
  logic               r_start, w_start_nxt;
  logic [1:0]         r_table, w_table_nxt;
  logic [TIME_W-1:0]  r_sec, w_sec_nxt;
  logic [PSW-1:0]     r_presc, w_presc_nxt;
  logic               r_ped_pending, w_ped_nxt;
  logic [3:0]         r_sync1, r_sync2;
  logic               r_ped_prev;

  logic               w_enter;
  logic [PW-1:0]      w_enter_phase;
  logic               w_ped_rise;
  logic [TIME_W-1:0]  w_dur_raw, w_dur;
  logic [TIME_W:0]    w_sec_inc;
  logic [TIME_W-1:0]  w_dur_tbl [N_TABLES][N_PHASES];

  for (genvar t = 0; t < N_TABLES; t++) begin : g_tbl
    for (genvar p = 0; p < N_PHASES; p++) begin : g_ph
      assign w_dur_tbl[t][p] = cfg_dur[(t*N_PHASES+p)*TIME_W +: TIME_W];
    end
  end

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p, input logic pend);
    logic [PW-1:0] n;
    n = (p == PW'(N_PHASES-1)) ? '0 : p + PW'(1);
    if (SKIP_PED && !pend && (n == PW'(PED_PHASE)))
      n = (n == PW'(N_PHASES-1)) ? '0 : n + PW'(1);
    return n;
  endfunction

  // Exactly one active sensor picks its table; silence or disagreement falls back to A.
  function automatic logic [1:0] f_table(input logic [2:0] s);
    logic [1:0] t;
    case (s)
      3'b100:  t = 2'd1;
      3'b010:  t = 2'd2;
      3'b001:  t = 2'd3;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

  // Bit order {ped_btn, STH, SNN, SNS}; the ped button keeps running while paused so presses are not lost.
  always_ff @(posedge CLK or posedge reset_general) begin
    if (reset_general) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_ped_prev <= 1'b0;
    end else begin
      r_sync1    <= {ped_btn, STH, SNN, SNS};
      r_sync2    <= r_sync1;
      r_ped_prev <= r_sync2[3];
    end
  end

  assign w_ped_rise = r_sync2[3] & ~r_ped_prev;
  assign w_dur_raw  = w_dur_tbl[r_table][r_phase];
  assign w_dur      = (w_dur_raw == '0) ? TIME_W'(1) : w_dur_raw;
  assign w_sec_inc  = {1'b0, r_sec} + (TIME_W+1)'(1);

  always_ff @(posedge CLK or posedge reset_general) begin
    if (reset_general) begin
      r_state       <= S_IDLE;
      r_phase       <= '0;
      r_start       <= 1'b0;
      r_table       <= 2'd0;
      r_sec         <= '0;
      r_presc       <= '0;
      r_ped_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_start       <= w_start_nxt;
      r_table       <= w_table_nxt;
      r_sec         <= w_sec_nxt;
      r_presc       <= w_presc_nxt;
      r_ped_pending <= w_ped_nxt;
    end
  end

  // Duration is compared live at every second wrap, so a shortened entry expires at the next wrap.
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_start_nxt   = 1'b0;
    w_table_nxt   = r_table;
    w_sec_nxt     = r_sec;
    w_presc_nxt   = r_presc;
    w_enter       = 1'b0;
    w_enter_phase = r_phase;

    case (r_state)
      S_IDLE: begin
        if (enable_general) begin
          w_enter       = 1'b1;
          w_enter_phase = f_next(PW'(N_PHASES-1), r_ped_pending);
        end
      end
      S_RUN: begin
        if (enable_general) begin
          if (r_presc == PSW'(CLK_PER_SEC-1)) begin
            w_presc_nxt = '0;
            if (w_sec_inc >= {1'b0, w_dur}) begin
              if (HOLD_MASK[r_phase] && !hold_ok) begin
                w_state_nxt = S_HOLD;
                w_sec_nxt   = w_dur;
              end else begin
                w_enter       = 1'b1;
                w_enter_phase = f_next(r_phase, r_ped_pending);
              end
            end else begin
              w_sec_nxt = w_sec_inc[TIME_W-1:0];
            end
          end else begin
            w_presc_nxt = r_presc + PSW'(1);
          end
        end
      end
      S_HOLD: begin
        if (enable_general && hold_ok) begin
          w_enter       = 1'b1;
          w_enter_phase = f_next(r_phase, r_ped_pending);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_enter) begin
      w_state_nxt = S_RUN;
      w_phase_nxt = w_enter_phase;
      w_start_nxt = 1'b1;
      w_table_nxt = f_table(r_sync2[2:0]);
      w_sec_nxt   = '0;
      w_presc_nxt = '0;
    end

    w_ped_nxt = w_ped_rise |
                (r_ped_pending & ~(w_enter && (w_enter_phase == PW'(PED_PHASE))));
  end

  always_comb begin
    phase       = r_phase;
    phase_valid = (r_state != S_IDLE);
    phase_start = r_start;
    table_sel   = r_table;
    sec_elapsed = r_sec;
    ped_pending = r_ped_pending;
    hold_wait   = (r_state == S_HOLD);
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer: directed vector table, hand sequences for
// holds, table selection, pausing, async reset and zero durations, then random stimulus against a model.
module tb_traffic_phase_sequencer;

  localparam int NP  = 4;
  localparam int NT  = 4;
  localparam int TW  = 8;
  localparam int CPS = 4;
  localparam logic [NP-1:0] HMASK = 4'b0100;

  logic             CLK = 1'b0;
  logic             reset_general, enable_general, SNN, SNS, STH, ped_btn, hold_ok;
  logic [NT*NP*TW-1:0] cfg_dur;
  logic [1:0]       phase, table_sel;
  logic             phase_valid, phase_start, ped_pending, hold_wait;
  logic [TW-1:0]    sec_elapsed;

  traffic_phase_sequencer #(
    .N_PHASES(NP), .N_TABLES(NT), .TIME_W(TW), .CLK_PER_SEC(CPS),
    .PED_PHASE(0), .SKIP_PED(1'b1), .HOLD_MASK(HMASK)
  ) dut (
    .CLK(CLK), .reset_general(reset_general), .enable_general(enable_general),
    .SNN(SNN), .SNS(SNS), .STH(STH), .ped_btn(ped_btn), .hold_ok(hold_ok),
    .cfg_dur(cfg_dur), .phase(phase), .phase_valid(phase_valid),
    .phase_start(phase_start), .table_sel(table_sel), .sec_elapsed(sec_elapsed),
    .ped_pending(ped_pending), .hold_wait(hold_wait)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] ph;
    logic       vld;
    logic       st;
    logic [1:0] tsel;
    logic [7:0] sec;
    logic       pend;
    logic       hw;
  } outs_t;

  typedef struct {
    logic       en;
    logic       ped;
    logic       hok;
    logic [2:0] sens;
    int         cyc;
    outs_t      exp;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Reference model: counts enabled cycles inside a phase rather than seconds and prescaler.
  bit         mRun, mHold, mPend, mStart, mPedPrev;
  int         mPhase, mCount, mTable;
  logic [3:0] mS1, mS2;

  function automatic outs_t mk(int ph, bit v, bit s, int t, int sec, bit p, bit h);
    outs_t o;
    o.ph = 2'(ph); o.vld = v; o.st = s; o.tsel = 2'(t);
    o.sec = 8'(sec); o.pend = p; o.hw = h;
    return o;
  endfunction

  function automatic int durOf(int t, int p);
    int v;
    v = int'(cfg_dur[(t*NP+p)*TW +: TW]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int nextPh(int p, bit pend);
    int n;
    n = (p + 1) % NP;
    if (n == 0 && !pend) n = (n + 1) % NP;
    return n;
  endfunction

  function automatic int tableOf(logic [2:0] s);
    case (s)
      3'b100:  return 1;
      3'b010:  return 2;
      3'b001:  return 3;
      default: return 0;
    endcase
  endfunction

  task automatic modelReset();
    mRun = 0; mHold = 0; mPend = 0; mStart = 0; mPedPrev = 0;
    mPhase = 0; mCount = 0; mTable = 0; mS1 = '0; mS2 = '0;
  endtask

  task automatic modelStep(input logic en, input logic ped, input logic hok, input logic [2:0] sens);
    bit rise, entered;
    int np;
    logic [2:0] seenSens;
    rise     = mS2[3] && !mPedPrev;
    seenSens = mS2[2:0];
    mPedPrev = mS2[3];
    mS2      = mS1;
    mS1      = {ped, sens};
    mStart   = 0;
    entered  = 0;
    np       = mPhase;
    if (!mRun) begin
      if (en) begin entered = 1; np = nextPh(NP-1, mPend); end
    end else if (en) begin
      if (mHold) begin
        if (hok) begin entered = 1; np = nextPh(mPhase, mPend); end
      end else begin
        mCount++;
        if (mCount >= durOf(mTable, mPhase) * CPS) begin
          if (HMASK[mPhase] && !hok) mHold = 1;
          else begin entered = 1; np = nextPh(mPhase, mPend); end
        end
      end
    end
    if (entered) begin
      mRun = 1; mHold = 0; mPhase = np; mCount = 0;
      mTable = tableOf(seenSens); mStart = 1;
    end
    mPend = rise || (mPend && !(entered && np == 0));
  endtask

  function automatic outs_t modelOut();
    return mk(mPhase, mRun, mStart, mTable,
              mHold ? durOf(mTable, mPhase) : mCount / CPS, mPend, mHold);
  endfunction

  task automatic applyStimulus(input logic en, input logic ped, input logic hok, input logic [2:0] sens);
    enable_general = en; ped_btn = ped; hold_ok = hok;
    {STH, SNN, SNS} = sens;
    @(posedge CLK);
    modelStep(en, ped, hok, sens);
    #1;
  endtask

  task automatic run(input int n, input logic en, input logic ped, input logic hok, input logic [2:0] sens);
    repeat (n) applyStimulus(en, ped, hok, sens);
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = {phase, phase_valid, phase_start, table_sel, sec_elapsed, ped_pending, hold_wait};
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got ph=%0d vld=%0b st=%0b tsel=%0d sec=%0d pend=%0b hold=%0b, expected ph=%0d vld=%0b st=%0b tsel=%0d sec=%0d pend=%0b hold=%0b",
                  name, act.ph, act.vld, act.st, act.tsel, act.sec, act.pend, act.hw,
                  exp.ph, exp.vld, exp.st, exp.tsel, exp.sec, exp.pend, exp.hw);
  endtask

  task automatic doReset();
    reset_general = 1'b1;
    enable_general = 0; ped_btn = 0; hold_ok = 0; STH = 0; SNN = 0; SNS = 0;
    modelReset();
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset values", mk(0, 0, 0, 0, 0, 0, 0));
    reset_general = 1'b0;
  endtask

  task automatic setField(input int t, input int p, input int v);
    cfg_dur[(t*NP+p)*TW +: TW] = TW'(v);
  endtask

  task automatic setDefaultCfg();
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < NP; p++) setField(t, p, 1);
    setField(0, 0, 2); setField(0, 1, 1); setField(0, 2, 3); setField(0, 3, 1);
    setField(1, 2, 5);
  endtask

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] rs;
    logic rp, rh, re;

    // Ped held high from release: one press latched, phase 0 served once, then skipped again.
    vecs[0]  = '{1, 1, 1, 3'b000, 1,  mk(1, 1, 1, 0, 0, 0, 0)};
    vecs[1]  = '{1, 1, 1, 3'b000, 2,  mk(1, 1, 0, 0, 0, 1, 0)};
    vecs[2]  = '{1, 1, 1, 3'b000, 1,  mk(1, 1, 0, 0, 0, 1, 0)};
    vecs[3]  = '{1, 1, 1, 3'b000, 1,  mk(2, 1, 1, 0, 0, 1, 0)};
    vecs[4]  = '{1, 1, 1, 3'b000, 4,  mk(2, 1, 0, 0, 1, 1, 0)};
    vecs[5]  = '{1, 1, 1, 3'b000, 7,  mk(2, 1, 0, 0, 2, 1, 0)};
    vecs[6]  = '{1, 1, 1, 3'b000, 1,  mk(3, 1, 1, 0, 0, 1, 0)};
    vecs[7]  = '{1, 1, 1, 3'b000, 4,  mk(0, 1, 1, 0, 0, 0, 0)};
    vecs[8]  = '{1, 1, 1, 3'b000, 7,  mk(0, 1, 0, 0, 1, 0, 0)};
    vecs[9]  = '{1, 1, 1, 3'b000, 1,  mk(1, 1, 1, 0, 0, 0, 0)};
    vecs[10] = '{1, 1, 1, 3'b000, 4,  mk(2, 1, 1, 0, 0, 0, 0)};
    vecs[11] = '{1, 1, 1, 3'b000, 12, mk(3, 1, 1, 0, 0, 0, 0)};
    vecs[12] = '{1, 1, 1, 3'b000, 4,  mk(1, 1, 1, 0, 0, 0, 0)};

    cfg_dur = '0;
    setDefaultCfg();
    doReset();
    run(3, 0, 0, 0, 3'b000);
    checkOutput("idle while disabled", mk(0, 0, 0, 0, 0, 0, 0));
    doReset();
    for (int i = 0; i < 13; i++) begin
      run(vecs[i].cyc, vecs[i].en, vecs[i].ped, vecs[i].hok, vecs[i].sens);
      checkOutput($sformatf("vector %0d", i), vecs[i].exp);
    end

    // Hold on phase 2 with a pedestrian pulse during it.
    doReset();
    run(5, 1, 0, 0, 3'b000);
    checkOutput("hold: enter phase 2", mk(2, 1, 1, 0, 0, 0, 0));
    run(1, 1, 1, 0, 3'b000);
    run(2, 1, 0, 0, 3'b000);
    checkOutput("hold: ped latched", mk(2, 1, 0, 0, 0, 1, 0));
    run(9, 1, 0, 0, 3'b000);
    checkOutput("hold: entered", mk(2, 1, 0, 0, 3, 1, 1));
    run(5, 1, 0, 0, 3'b000);
    checkOutput("hold: still waiting", mk(2, 1, 0, 0, 3, 1, 1));
    run(1, 1, 0, 1, 3'b000);
    checkOutput("hold: released", mk(3, 1, 1, 0, 0, 1, 0));
    run(4, 1, 0, 0, 3'b000);
    checkOutput("hold: ped phase served", mk(0, 1, 1, 0, 0, 0, 0));

    // STH alone during phase 1 selects table B for phase 2 (5 s).
    doReset();
    run(1, 1, 0, 1, 3'b000);
    run(3, 1, 0, 1, 3'b100);
    checkOutput("table: phase 1 on A", mk(1, 1, 0, 0, 0, 0, 0));
    run(1, 1, 0, 1, 3'b100);
    checkOutput("table: phase 2 on B", mk(2, 1, 1, 1, 0, 0, 0));
    run(19, 1, 0, 1, 3'b000);
    checkOutput("table: B phase late", mk(2, 1, 0, 1, 4, 0, 0));
    run(1, 1, 0, 1, 3'b000);
    checkOutput("table: back to A", mk(3, 1, 1, 0, 0, 0, 0));

    // Pause for three cycles stretches phase 1 by exactly three cycles; then async reset.
    doReset();
    run(2, 1, 0, 1, 3'b000);
    run(3, 0, 0, 1, 3'b000);
    checkOutput("pause: frozen", mk(1, 1, 0, 0, 0, 0, 0));
    run(2, 1, 0, 1, 3'b000);
    checkOutput("pause: not yet expired", mk(1, 1, 0, 0, 0, 0, 0));
    run(1, 1, 0, 1, 3'b000);
    checkOutput("pause: expired late", mk(2, 1, 1, 0, 0, 0, 0));
    #2 reset_general = 1'b1;
    #1 checkOutput("async reset", mk(0, 0, 0, 0, 0, 0, 0));

    // A zero duration field behaves like one second.
    setField(0, 3, 0);
    doReset();
    run(17, 1, 0, 1, 3'b000);
    checkOutput("zero dur: phase 3 entry", mk(3, 1, 1, 0, 0, 0, 0));
    run(3, 1, 0, 1, 3'b000);
    checkOutput("zero dur: phase 3 last", mk(3, 1, 0, 0, 0, 0, 0));
    run(1, 1, 0, 1, 3'b000);
    checkOutput("zero dur: wrap", mk(1, 1, 1, 0, 0, 0, 0));

    // Random inputs with random durations, compared with the model every cycle.
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < NP; p++) setField(t, p, int'($urandom_range(0, 3)));
    doReset();
    rs = '0; rp = 0;
    for (int i = 0; i < 3000; i++) begin
      re = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) rs = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) rp = ~rp;
      rh = ($urandom_range(0, 3) == 0);
      applyStimulus(re, rp, rh, rs);
      checkOutput("random", modelOut());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
